// File: rtl/network_bf_in_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : network_bf_in_pkg                                            |
// | Description : Shared types and constants for the bank/butterfly routing    |
// |               networks (read side and write side use the same slot codes). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package network_bf_in_pkg;

  localparam int BANK_W         = 2;
  localparam int NUM_BANKS      = 1 << BANK_W;
  localparam int NUM_SLOTS      = 4;
  localparam int DATA_WIDTH_DEF = 14;

  typedef logic [BANK_W-1:0] bank_idx_t;

  // Butterfly operand slots; the write-side network uses the same numbering.
  typedef enum logic [1:0] {
    SLOT_BF0_LO = 2'd0,
    SLOT_BF0_UP = 2'd1,
    SLOT_BF1_LO = 2'd2,
    SLOT_BF1_UP = 2'd3
  } slot_e;

  // Tag travelling alongside a read beat. The valid bit is the MSB so the
  // generic delay line can clear it without knowing the struct layout.
  typedef struct packed {
    logic                        valid;
    bank_idx_t [NUM_SLOTS-1:0]   sel;
  } rd_tag_t;

  // True when the slot selects are not a permutation of the banks.
  function automatic logic sel_conflict(input bank_idx_t [NUM_SLOTS-1:0] sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = i + 1; j < NUM_SLOTS; j++) begin
        if (sel[i] == sel[j]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/network_bf_in_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : network_bf_in_if                                             |
// | Description : Bus bundle for the read-side routing network.                |
// |               master: issues beats, supplies bank data, reads operands.    |
// |               slave : the routing network itself.                          |
// |   in_valid, sel_b_0..3, q0..q3, flush, err_clr : master -> slave          |
// |   bf_0/1_upper/lower, out_valid, err_conflict, beat_cnt : slave -> master  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface network_bf_in_if
  import network_bf_in_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = 9
) ();

  logic                  in_valid;
  logic [BANK_W-1:0]     sel_b_0;
  logic [BANK_W-1:0]     sel_b_1;
  logic [BANK_W-1:0]     sel_b_2;
  logic [BANK_W-1:0]     sel_b_3;
  logic [DATA_WIDTH-1:0] q0;
  logic [DATA_WIDTH-1:0] q1;
  logic [DATA_WIDTH-1:0] q2;
  logic [DATA_WIDTH-1:0] q3;
  logic                  flush;
  logic                  err_clr;

  logic [DATA_WIDTH-1:0] bf_0_upper;
  logic [DATA_WIDTH-1:0] bf_0_lower;
  logic [DATA_WIDTH-1:0] bf_1_upper;
  logic [DATA_WIDTH-1:0] bf_1_lower;
  logic                  out_valid;
  logic                  err_conflict;
  logic [CNT_W-1:0]      beat_cnt;

  modport master (
    output in_valid, sel_b_0, sel_b_1, sel_b_2, sel_b_3,
           q0, q1, q2, q3, flush, err_clr,
    input  bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower,
           out_valid, err_conflict, beat_cnt
  );

  modport slave (
    input  in_valid, sel_b_0, sel_b_1, sel_b_2, sel_b_3,
           q0, q1, q2, q3, flush, err_clr,
    output bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower,
           out_valid, err_conflict, beat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/network_bf_in_sel_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : network_bf_in_sel_pipe                                       |
// | Description : DEPTH-stage delay line for a tag word whose MSB is a valid   |
// |               bit. flush clears every valid bit (including the incoming    |
// |               one) at the same edge; payload bits keep shifting.           |
// |   clk, rst (async, active-low), flush, in_data[WIDTH] -> out_data[WIDTH]  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module network_bf_in_sel_pipe #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] in_data,
  output logic      [WIDTH-1:0] out_data
);

  localparam int VALID_BIT = WIDTH - 1;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i][VALID_BIT] = stage_d[i][VALID_BIT] & ~flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_data = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/network_bf_in.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : network_bf_in                                                |
// | Description : Read-side routing network: steers bank data q0..q3 onto the  |
// |               two butterfly operand pairs using per-slot bank selects that |
// |               are delayed RD_LAT cycles to meet the returning read data.   |
// |               Flags non-permutation selects and counts delivered beats.    |
// |   clk             : clock, rising edge                                     |
// |   rst             : asynchronous reset, active-low                         |
// |   bus (slave)     : issue/select/bank-data inputs, registered operands,    |
// |                     out_valid, sticky err_conflict, beat_cnt               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module network_bf_in
  import network_bf_in_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 9
) (
  input wire logic        clk,
  input wire logic        rst,
  network_bf_in_if.slave  bus
);

  localparam int TAG_W = $bits(rd_tag_t);

  rd_tag_t               issue_tag;
  rd_tag_t               dly_tag;
  logic [DATA_WIDTH-1:0] q_bank [NUM_BANKS];
  logic                  load;

  logic [DATA_WIDTH-1:0] bf_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] bf_d [NUM_SLOTS];
  logic                  out_valid_q, out_valid_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    issue_tag                  = '0;
    issue_tag.valid            = bus.in_valid;
    issue_tag.sel[SLOT_BF0_LO] = bus.sel_b_0;
    issue_tag.sel[SLOT_BF0_UP] = bus.sel_b_1;
    issue_tag.sel[SLOT_BF1_LO] = bus.sel_b_2;
    issue_tag.sel[SLOT_BF1_UP] = bus.sel_b_3;
  end

  network_bf_in_sel_pipe #(
    .WIDTH (TAG_W),
    .DEPTH (RD_LAT)
  ) u_sel_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .in_data  (issue_tag),
    .out_data (dly_tag)
  );

  always_comb begin
    q_bank[0] = bus.q0;
    q_bank[1] = bus.q1;
    q_bank[2] = bus.q2;
    q_bank[3] = bus.q3;
  end

  always_comb begin
    // A flush in the same cycle kills the beat that is about to land, so the
    // operand registers keep their previous contents.
    load        = dly_tag.valid & ~bus.flush;
    out_valid_d = load;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      bf_d[s] = load ? q_bank[dly_tag.sel[s]] : bf_q[s];
    end
    // Checked at issue, independent of flush; a new conflict beats err_clr.
    err_d = (bus.in_valid & sel_conflict(issue_tag.sel)) | (err_q & ~bus.err_clr);
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, out_valid_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        bf_q[s] <= '0;
      end
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bf_q        <= bf_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.bf_0_lower   = bf_q[SLOT_BF0_LO];
  assign bus.bf_0_upper   = bf_q[SLOT_BF0_UP];
  assign bus.bf_1_lower   = bf_q[SLOT_BF1_LO];
  assign bus.bf_1_upper   = bf_q[SLOT_BF1_UP];
  assign bus.out_valid    = out_valid_q;
  assign bus.err_conflict = err_q;
  assign bus.beat_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_network_bf_in.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_network_bf_in                                             |
// | Description : Directed bench for network_bf_in; one DUT with RD_LAT=1 and  |
// |               one with RD_LAT=3. Bank data is held constant per DUT        |
// |               (q_k = 0x10+k and 0x20+k) so each operand names its bank.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_network_bf_in;
  import network_bf_in_pkg::*;

  localparam int DW = 14;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  network_bf_in_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus1 ();
  network_bf_in_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus3 ();

  network_bf_in #(.DATA_WIDTH(DW), .RD_LAT(1), .CNT_W(CW)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  network_bf_in #(.DATA_WIDTH(DW), .RD_LAT(3), .CNT_W(CW)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3,
                        input logic fl, input logic ec);
    bus1.in_valid = v;
    bus1.sel_b_0  = s0;
    bus1.sel_b_1  = s1;
    bus1.sel_b_2  = s2;
    bus1.sel_b_3  = s3;
    bus1.flush    = fl;
    bus1.err_clr  = ec;
  endtask

  task automatic idle1();
    drive1(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle1();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle1();
    rst = 1'b0;
    step();
    n_vec++;
    if ({bus1.out_valid, bus1.err_conflict, bus1.beat_cnt} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_ctl1 got %b want 0", {bus1.out_valid, bus1.err_conflict, bus1.beat_cnt});
    end
    n_vec++;
    if ({bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !== 56'd0) begin
      n_err++;
      $display("FAIL reset_bf1 got %h want 0", {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper});
    end
    n_vec++;
    if ({bus3.out_valid, bus3.err_conflict, bus3.beat_cnt} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_ctl3 got %b want 0", {bus3.out_valid, bus3.err_conflict, bus3.beat_cnt});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_identity();
    drive1(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
    step();
    idle1();
    n_vec++;
    if (bus1.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ident_early out_valid got %b want 0", bus1.out_valid);
    end
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ident_valid got %b want 1", bus1.out_valid);
    end
    n_vec++;
    if ({bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h10, 14'h11, 14'h12, 14'h13}) begin
      n_err++;
      $display("FAIL ident_bf got %h %h %h %h want 10 11 12 13",
               bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
    step();
    n_vec++;
    if ({bus1.out_valid, bus1.beat_cnt, bus1.err_conflict} !== {1'b0, 9'd1, 1'b0}) begin
      n_err++;
      $display("FAIL ident_after valid/cnt/err got %b/%0d/%b want 0/1/0",
               bus1.out_valid, bus1.beat_cnt, bus1.err_conflict);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e0, e1, e2, e3;
    int b;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive1(1'b1, 2'(c), 2'(c + 1), 2'(c + 2), 2'(c + 3), 1'b0, 1'b0);
      else       idle1();
      step();
      if (c >= 1 && c <= 8) begin
        b  = c - 1;
        e0 = DW'(16 + (b % 4));
        e1 = DW'(16 + ((b + 1) % 4));
        e2 = DW'(16 + ((b + 2) % 4));
        e3 = DW'(16 + ((b + 3) % 4));
        n_vec++;
        if (bus1.out_valid !== 1'b1 ||
            {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !== {e0, e1, e2, e3}) begin
          n_err++;
          $display("FAIL b2b beat%0d got v=%b %h %h %h %h want v=1 %h %h %h %h", b, bus1.out_valid,
                   bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper, e0, e1, e2, e3);
        end
      end
    end
    n_vec++;
    if ({bus1.out_valid, bus1.beat_cnt, bus1.err_conflict} !== {1'b0, 9'd8, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_end valid/cnt/err got %b/%0d/%b want 0/8/0",
               bus1.out_valid, bus1.beat_cnt, bus1.err_conflict);
    end
  endtask

  task automatic test_conflict();
    drive1(1'b1, 2'd2, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0);
    step();
    idle1();
    n_vec++;
    if (bus1.err_conflict !== 1'b1) begin
      n_err++;
      $display("FAIL conf_set got %b want 1", bus1.err_conflict);
    end
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b1 || bus1.err_conflict !== 1'b1 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h12, 14'h12, 14'h10, 14'h11}) begin
      n_err++;
      $display("FAIL conf_route got v=%b e=%b %h %h %h %h want v=1 e=1 12 12 10 11", bus1.out_valid,
               bus1.err_conflict, bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
    drive1(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    step();
    idle1();
    n_vec++;
    if (bus1.err_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conf_clr got %b want 0", bus1.err_conflict);
    end
    // Equal selects without in_valid are not a conflict.
    drive1(1'b0, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
    step();
    n_vec++;
    if (bus1.err_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conf_novalid got %b want 0", bus1.err_conflict);
    end
    drive1(1'b1, 2'd1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1);
    step();
    idle1();
    n_vec++;
    if (bus1.err_conflict !== 1'b1) begin
      n_err++;
      $display("FAIL conf_setwins got %b want 1", bus1.err_conflict);
    end
    step();
    n_vec++;
    if ({bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h11, 14'h10, 14'h11, 14'h12}) begin
      n_err++;
      $display("FAIL conf_dup got %h %h %h %h want 11 10 11 12",
               bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
    drive1(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    step();
    idle1();
    n_vec++;
    if (bus1.err_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conf_clr2 got %b want 0", bus1.err_conflict);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive1(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
    step();
    idle1();
    step();
    step();
    // beats t..t+3, flush alongside beat t+1
    drive1(1'b1, 2'd1, 2'd2, 2'd3, 2'd0, 1'b0, 1'b0);
    step();
    drive1(1'b1, 2'd2, 2'd3, 2'd0, 2'd1, 1'b1, 1'b0);
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b0 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h10, 14'h11, 14'h12, 14'h13}) begin
      n_err++;
      $display("FAIL flush_t got v=%b %h %h %h %h want v=0 10 11 12 13", bus1.out_valid,
               bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
    drive1(1'b1, 2'd3, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0);
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b0 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h10, 14'h11, 14'h12, 14'h13}) begin
      n_err++;
      $display("FAIL flush_t1 got v=%b %h %h %h %h want v=0 10 11 12 13", bus1.out_valid,
               bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
    drive1(1'b1, 2'd1, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0);
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b1 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h13, 14'h10, 14'h11, 14'h12}) begin
      n_err++;
      $display("FAIL flush_t2 got v=%b %h %h %h %h want v=1 13 10 11 12", bus1.out_valid,
               bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
    idle1();
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b1 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h11, 14'h10, 14'h13, 14'h12}) begin
      n_err++;
      $display("FAIL flush_t3 got v=%b %h %h %h %h want v=1 11 10 13 12", bus1.out_valid,
               bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b0 || bus1.beat_cnt !== 9'd3 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h11, 14'h10, 14'h13, 14'h12}) begin
      n_err++;
      $display("FAIL flush_hold got v=%b cnt=%0d %h %h %h %h want v=0 cnt=3 11 10 13 12",
               bus1.out_valid, bus1.beat_cnt, bus1.bf_0_lower, bus1.bf_0_upper,
               bus1.bf_1_lower, bus1.bf_1_upper);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 511; i++) begin
      drive1(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
      step();
    end
    idle1();
    repeat (3) step();
    n_vec++;
    if (bus1.beat_cnt !== 9'd511) begin
      n_err++;
      $display("FAIL wrap_511 got %0d want 511", bus1.beat_cnt);
    end
    drive1(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
    step();
    idle1();
    repeat (3) step();
    n_vec++;
    if (bus1.beat_cnt !== 9'd0 || bus1.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_0 got cnt=%0d v=%b want cnt=0 v=0", bus1.beat_cnt, bus1.out_valid);
    end
  endtask

  task automatic test_latency3();
    bus3.in_valid = 1'b1;
    bus3.sel_b_0  = 2'd3;
    bus3.sel_b_1  = 2'd2;
    bus3.sel_b_2  = 2'd1;
    bus3.sel_b_3  = 2'd0;
    step();
    bus3.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_vec++;
      if (bus3.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL lat3_early cycle+%0d got %b want 0", k, bus3.out_valid);
      end
      step();
    end
    n_vec++;
    if (bus3.out_valid !== 1'b1 ||
        {bus3.bf_0_lower, bus3.bf_0_upper, bus3.bf_1_lower, bus3.bf_1_upper} !==
        {14'h23, 14'h22, 14'h21, 14'h20}) begin
      n_err++;
      $display("FAIL lat3_beat got v=%b %h %h %h %h want v=1 23 22 21 20", bus3.out_valid,
               bus3.bf_0_lower, bus3.bf_0_upper, bus3.bf_1_lower, bus3.bf_1_upper);
    end
    step();
    n_vec++;
    if (bus3.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lat3_after got %b want 0", bus3.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive1(1'b1, 2'd0, 2'd0, 2'd2, 2'd3, 1'b0, 1'b0);
    step();
    drive1(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0);
    step();
    step();
    n_vec++;
    if ({bus1.out_valid, bus1.err_conflict, bus1.beat_cnt} !== {1'b1, 1'b1, 9'd1}) begin
      n_err++;
      $display("FAIL rmid_pre v/err/cnt got %b/%b/%0d want 1/1/1",
               bus1.out_valid, bus1.err_conflict, bus1.beat_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus1.out_valid, bus1.err_conflict, bus1.beat_cnt} !== 11'd0 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !== 56'd0) begin
      n_err++;
      $display("FAIL rmid_async1 got v=%b e=%b cnt=%0d bf=%h want all 0", bus1.out_valid,
               bus1.err_conflict, bus1.beat_cnt,
               {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper});
    end
    n_vec++;
    if ({bus3.bf_0_lower, bus3.bf_0_upper, bus3.bf_1_lower, bus3.bf_1_upper} !== 56'd0) begin
      n_err++;
      $display("FAIL rmid_async3 got bf=%h want 0",
               {bus3.bf_0_lower, bus3.bf_0_upper, bus3.bf_1_lower, bus3.bf_1_upper});
    end
    idle1();
    step();
    rst = 1'b1;
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_ghost got %b want 0", bus1.out_valid);
    end
    drive1(1'b1, 2'd3, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0);
    step();
    idle1();
    n_vec++;
    if (bus1.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_early got %b want 0", bus1.out_valid);
    end
    step();
    n_vec++;
    if (bus1.out_valid !== 1'b1 ||
        {bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper} !==
        {14'h13, 14'h11, 14'h10, 14'h12}) begin
      n_err++;
      $display("FAIL rmid_first got v=%b %h %h %h %h want v=1 13 11 10 12", bus1.out_valid,
               bus1.bf_0_lower, bus1.bf_0_upper, bus1.bf_1_lower, bus1.bf_1_upper);
    end
  endtask

  initial begin
    bus1.q0 = 14'h10; bus1.q1 = 14'h11; bus1.q2 = 14'h12; bus1.q3 = 14'h13;
    bus3.q0 = 14'h20; bus3.q1 = 14'h21; bus3.q2 = 14'h22; bus3.q3 = 14'h23;
    bus3.in_valid = 1'b0;
    bus3.sel_b_0  = 2'd0;
    bus3.sel_b_1  = 2'd1;
    bus3.sel_b_2  = 2'd2;
    bus3.sel_b_3  = 2'd3;
    bus3.flush    = 1'b0;
    bus3.err_clr  = 1'b0;
    idle1();

    test_reset();
    test_identity();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_wrap();
    test_latency3();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
